// File: rtl/bound_flasher_param_if.sv
// Control/status bundle of the bound flasher: the sequencer drives flick/step_en,
// the flasher returns the LED bar and its status.
interface bound_flasher_param_if #(
  parameter int WIDTH = 16
);
  logic             flick;
  logic             step_en;
  logic [WIDTH-1:0] led_out;
  logic [2:0]       phase;
  logic             busy;
  logic             done;

  modport master (
    output flick,
    output step_en,
    input  led_out,
    input  phase,
    input  busy,
    input  done
  );

  modport slave (
    input  flick,
    input  step_en,
    output led_out,
    output phase,
    output busy,
    output done
  );
endinterface

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: thermometer LED bar bouncing between two bounds and
// the full bar, with flick-controlled rollback and a step enable.
//
// state | meaning
// IDLE  | bar dark, waiting for flick
// UP1   | fill up to lower bound (B1+1 LEDs)
// DN1   | drain to 0, then UP1 again on rollback or on to UP2
// UP2   | fill up to upper bound (B2+1 LEDs)
// DN2   | drain to lower bound, then UP3 on rollback or UPTOP
// UPTOP | fill the whole bar
// DNF   | final drain to 0, pulses done
// UP3   | refill to upper bound after a rollback
module bound_flasher_param #(
  parameter int WIDTH = 16,
  parameter int B1    = 5,
  parameter int B2    = 10
) (
  input logic                  clk,
  input logic                  reset_n,
  bound_flasher_param_if.slave bus
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam logic [LW-1:0] T1  = LW'(B1 + 1);
  localparam logic [LW-1:0] T2  = LW'(B2 + 1);
  localparam logic [LW-1:0] TOP = LW'(WIDTH);

  if (WIDTH < 4 || WIDTH > 64 || B1 < 1 || B1 >= B2 || B2 >= WIDTH - 1) begin : g_param_check
    $error("bound_flasher_param: illegal WIDTH/B1/B2 combination");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP1   = 3'd1,
    DN1   = 3'd2,
    UP2   = 3'd3,
    DN2   = 3'd4,
    UPTOP = 3'd5,
    DNF   = 3'd6,
    UP3   = 3'd7
  } phase_t;

  phase_t           state, state_nxt;
  logic [LW-1:0]    lvl, lvl_nxt;
  logic             rb, rb_nxt;
  logic             done_q, done_nxt;
  logic [WIDTH-1:0] led_q, led_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      lvl    <= '0;
      rb     <= 1'b0;
      done_q <= 1'b0;
      led_q  <= '0;
    end else begin
      state  <= state_nxt;
      lvl    <= lvl_nxt;
      rb     <= rb_nxt;
      done_q <= done_nxt;
      led_q  <= led_nxt;
    end
  end

  // The phase change is taken on the same step that reaches the target level.
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    rb_nxt    = rb;
    done_nxt  = 1'b0;
    if (state == IDLE) begin
      if (bus.flick) state_nxt = UP1;
    end else if (bus.step_en) begin
      case (state)
        UP1: begin
          lvl_nxt = lvl + LW'(1);
          if (lvl_nxt == T1) begin
            rb_nxt    = bus.flick;
            state_nxt = DN1;
          end
        end
        DN1: begin
          lvl_nxt = lvl - LW'(1);
          if (lvl_nxt == '0) begin
            rb_nxt    = 1'b0;
            state_nxt = rb ? UP1 : UP2;
          end
        end
        UP2: begin
          lvl_nxt = lvl + LW'(1);
          if (lvl_nxt == T2) begin
            rb_nxt    = bus.flick;
            state_nxt = DN2;
          end
        end
        DN2: begin
          lvl_nxt = lvl - LW'(1);
          if (lvl_nxt == T1) begin
            rb_nxt    = 1'b0;
            state_nxt = rb ? UP3 : UPTOP;
          end
        end
        UP3: begin
          lvl_nxt = lvl + LW'(1);
          if (lvl_nxt == T2) begin
            rb_nxt    = bus.flick;
            state_nxt = bus.flick ? DN2 : DNF;
          end
        end
        UPTOP: begin
          lvl_nxt = lvl + LW'(1);
          if (lvl_nxt == TOP) state_nxt = DNF;
        end
        DNF: begin
          lvl_nxt = lvl - LW'(1);
          if (lvl_nxt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          lvl_nxt   = '0;
          rb_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      led_nxt[i] = (LW'(i) < lvl_nxt);
    end
  end

  assign bus.led_out = led_q;
  assign bus.phase   = state;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Bench for bound_flasher_param: table vectors, directed rollback/freeze/reset
// sequences and random stimulus against a level/phase reference model.
module tb_bound_flasher_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bound_flasher_param_if #(.WIDTH(16)) ia ();
  bound_flasher_param_if #(.WIDTH(8))  ib ();

  bound_flasher_param #(.WIDTH(16), .B1(5), .B2(10)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia.slave)
  );
  bound_flasher_param #(.WIDTH(8), .B1(2), .B2(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib.slave)
  );

  typedef struct {
    int lvl;
    int ph;
    bit rb;
    bit done;
  } model_t;

  typedef struct {
    bit          sel;
    bit          f;
    bit          s;
    int          n;
    logic [63:0] led;
    int          ph;
    bit          done;
  } vec_t;

  model_t ma, mb;
  vec_t   tbl[16];

  function automatic model_t mreset();
    model_t m;
    m.lvl = 0; m.ph = 0; m.rb = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  // Phase targets: odd phases climb, even phases descend.
  function automatic model_t mstep(model_t s, bit f, bit se, int w, int t1, int t2);
    model_t n;
    int tgt;
    n = s;
    n.done = 1'b0;
    if (s.ph == 0) begin
      if (f) n.ph = 1;
    end else if (se) begin
      case (s.ph)
        1: tgt = t1;
        2: tgt = 0;
        3: tgt = t2;
        4: tgt = t1;
        5: tgt = w;
        6: tgt = 0;
        default: tgt = t2;
      endcase
      n.lvl = s.lvl + ((s.ph % 2 == 1) ? 1 : -1);
      if (n.lvl == tgt) begin
        case (s.ph)
          1, 3: begin n.rb = f; n.ph = s.ph + 1; end
          2: begin n.ph = s.rb ? 1 : 3; n.rb = 1'b0; end
          4: begin n.ph = s.rb ? 7 : 5; n.rb = 1'b0; end
          5: n.ph = 6;
          6: begin n.ph = 0; n.done = 1'b1; end
          default: begin n.rb = f; n.ph = f ? 4 : 6; end
        endcase
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] therm(int lvl);
    logic [63:0] one;
    one = 64'd1;
    if (lvl >= 64) return '1;
    return (one << lvl) - 64'd1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit sel, input bit f, input bit s);
    ia.flick   = (sel == 1'b0) && f;
    ia.step_en = (sel == 1'b0) && s;
    ib.flick   = (sel == 1'b1) && f;
    ib.step_en = (sel == 1'b1) && s;
    @(posedge clk);
    ma = mstep(ma, ia.flick, ia.step_en, 16, 6, 11);
    mb = mstep(mb, ib.flick, ib.step_en, 8, 3, 5);
    #1;
    chk("led_a",   64'(ia.led_out), therm(ma.lvl));
    chk("phase_a", 64'(ia.phase),   64'(ma.ph));
    chk("busy_a",  64'(ia.busy),    64'(ma.ph != 0));
    chk("done_a",  64'(ia.done),    64'(ma.done));
    chk("led_b",   64'(ib.led_out), therm(mb.lvl));
    chk("phase_b", 64'(ib.phase),   64'(mb.ph));
    chk("busy_b",  64'(ib.busy),    64'(mb.ph != 0));
    chk("done_b",  64'(ib.done),    64'(mb.done));
  endtask

  task automatic run(input bit sel, input bit f, input bit s, input int n);
    for (int i = 0; i < n; i++) tick(sel, f, s);
  endtask

  task automatic chk_a(input string nm, input logic [63:0] led, input int ph, input bit dn);
    chk({nm, "_led"},   64'(ia.led_out), led);
    chk({nm, "_phase"}, 64'(ia.phase),   64'(ph));
    chk({nm, "_done"},  64'(ia.done),    64'(dn));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{1'b0, 1'b1, 1'b1, 1,  64'h0,    1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 6,  64'h3F,   2, 1'b0},
      '{1'b0, 1'b0, 1'b1, 6,  64'h0,    3, 1'b0},
      '{1'b0, 1'b0, 1'b1, 11, 64'h7FF,  4, 1'b0},
      '{1'b0, 1'b0, 1'b1, 5,  64'h3F,   5, 1'b0},
      '{1'b0, 1'b0, 1'b1, 10, 64'hFFFF, 6, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16, 64'h0,    0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1,  64'h0,    0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1,  64'h0,    1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 3,  64'h07,   2, 1'b0},
      '{1'b1, 1'b0, 1'b1, 3,  64'h0,    3, 1'b0},
      '{1'b1, 1'b0, 1'b1, 5,  64'h1F,   4, 1'b0},
      '{1'b1, 1'b0, 1'b1, 2,  64'h07,   5, 1'b0},
      '{1'b1, 1'b0, 1'b1, 5,  64'hFF,   6, 1'b0},
      '{1'b1, 1'b0, 1'b1, 8,  64'h0,    0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1,  64'h0,    0, 1'b0}
    };
    ia.flick = 1'b0; ia.step_en = 1'b0;
    ib.flick = 1'b0; ib.step_en = 1'b0;
    ma = mreset();
    mb = mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led_a",   64'(ia.led_out), 64'h0);
    chk("rst_phase_a", 64'(ia.phase),   64'h0);
    chk("rst_busy_a",  64'(ia.busy),    64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with step_en high and no flick.
    run(1'b0, 1'b0, 1'b1, 100);

    // Plain sequences, both geometries.
    foreach (tbl[k]) begin
      run(tbl[k].sel, tbl[k].f, tbl[k].s, tbl[k].n);
      chk("tbl_led",   tbl[k].sel ? 64'(ib.led_out) : 64'(ia.led_out), tbl[k].led);
      chk("tbl_phase", tbl[k].sel ? 64'(ib.phase)   : 64'(ia.phase),   64'(tbl[k].ph));
      chk("tbl_done",  tbl[k].sel ? 64'(ib.done)    : 64'(ia.done),    64'(tbl[k].done));
    end

    // Rollback at the lower bound: 66 steps in total.
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 5);
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 6);
    chk_a("rb1_s12", 64'h0, 1, 1'b0);
    run(1'b0, 1'b0, 1'b1, 54);
    chk_a("rb1_s66", 64'h0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk_a("rb1_after", 64'h0, 0, 1'b0);

    // Rollback at the upper bound, repeated once from UP3.
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 22);
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 5);
    chk_a("rb2_s28", 64'h3F, 7, 1'b0);
    run(1'b0, 1'b0, 1'b1, 4);
    tick(1'b0, 1'b1, 1'b1);
    chk_a("rb2_s33", 64'h7FF, 4, 1'b0);
    run(1'b0, 1'b0, 1'b1, 5);
    chk_a("rb2_s38", 64'h3F, 7, 1'b0);
    run(1'b0, 1'b0, 1'b1, 5);
    chk_a("rb2_s43", 64'h7FF, 6, 1'b0);
    run(1'b0, 1'b0, 1'b1, 11);
    chk_a("rb2_s54", 64'h0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Freeze at lvl 8 in UP2 with flick toggling.
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 20);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, bit'(i % 2), 1'b0);
      chk_a("freeze", 64'h00FF, 3, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b1);
    chk_a("resume", 64'h01FF, 3, 1'b0);
    run(1'b0, 1'b0, 1'b1, 33);
    chk_a("freeze_end", 64'h0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-DN2 at lvl 9.
    tick(1'b0, 1'b1, 1'b1);
    run(1'b0, 1'b0, 1'b1, 25);
    chk_a("pre_rst", 64'h1FF, 4, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_led",   64'(ia.led_out), 64'h0);
    chk("arst_phase", 64'(ia.phase),   64'h0);
    chk("arst_busy",  64'(ia.busy),    64'h0);
    ma = mreset();
    mb = mreset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, 1'b0, 1'b1, 10);
    chk_a("post_rst", 64'h0, 0, 1'b0);

    // Random flick/step_en on both instances.
    for (int i = 0; i < 3000; i++) begin
      tick(bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
